fifo_rd_arbiter: RTL and testbench

- Round-robin arbiter that shares the single FIFO read port (fifo_rd_en / rd_data / fifo_empty / fifo_rd_err) among NREQ requesters.
- Issues at most one read per cycle and supports bounded bursts per grant.
- Tracks each issued read through a RD_LAT-deep tag pipeline, so returning data and error are steered to the requester that issued it.
- Sits between client logic and the FIFO read-side block.

---
 rtl/fifo_rd_arbiter_pkg.sv | 27 ++
 rtl/fifo_rd_arbiter_if.sv | 29 ++
 rtl/fifo_rd_arbiter_rr_pick.sv | 38 +++
 rtl/fifo_rd_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_arbiter_pkg.sv
// fifo_param_pkg
//   Shared types and default sizing for the FIFO read-port arbiter.
//   arb_state_t : arbiter FSM states.
//   tag_t       : one tag-pipeline entry that follows an issued read
//                 until its data returns.
//   *_DEF       : default parameter values used by the arbiter.
package fifo_param_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int DATA_W_DEF    = 32;
    localparam int RD_LAT_DEF    = 2;
    localparam int MAX_BURST_DEF = 4;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if
//   Groups the requester-side and FIFO-side signals of the read arbiter.
//   master : arbiter view (drives gnt, fifo_rd_en, rvalid, rdata, rerr, busy)
//   slave  : client/FIFO view (drives req, fifo_empty, fifo_rd_data, fifo_rd_err)
interface fifo_rd_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic              fifo_rd_en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_err;
    logic [NREQ-1:0]   rvalid;
    logic [DATA_W-1:0] rdata;
    logic [NREQ-1:0]   rerr;
    logic              busy;

    modport master (
        input  req, fifo_empty, fifo_rd_data, fifo_rd_err,
        output gnt, fifo_rd_en, rvalid, rdata, rerr, busy
    );

    modport slave (
        output req, fifo_empty, fifo_rd_data, fifo_rd_err,
        input  gnt, fifo_rd_en, rvalid, rdata, rerr, busy
    );
endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker: returns the first set request at or
//   after ptr, searching cyclically.
//   req : request vector        ptr : search start index
//   gnt : one-hot winner        idx : winner index      any : a winner exists
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IW'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
//   Round-robin arbiter sharing one FIFO read port among NREQ requesters,
//   with bounded bursts per grant and tagged return steering.
//   CLK, RST  : clock, synchronous active-high reset
//   bus       : fifo_rd_arbiter_if.master (req/gnt, FIFO strobe/data/err,
//               rvalid/rdata/rerr returns, busy)
//   Optional (macro FIFO_RD_ARB_STATS_EN):
//   stats_clr : clears the grant counters
//   gnt_cnt   : NREQ x 16-bit saturating grant counters, requester i in
//               bits [16*i +: 16]
//
//   state | meaning
//   IDLE  | no owner; arbitrate among requesters each cycle
//   BURST | owner holds the port until req drops, FIFO empties or
//         | MAX_BURST reads are issued, then re-arbitrates same cycle
module fifo_rd_arbiter
    import fifo_param_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input logic CLK,
    input logic RST,
    fifo_rd_arbiter_if.master bus
`ifdef FIFO_RD_ARB_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [NREQ*16-1:0] gnt_cnt
`endif
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t      state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   ptr, ptr_nxt, pick_ptr, pick_idx, gnt_idx;
    logic [BW-1:0]   burst_cnt, burst_nxt;
    logic [NREQ-1:0] pick_gnt, gnt, ret_sel;
    logic            pick_any, keep, in_flight;
    tag_t            pipe [RD_LAT];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        burst_nxt = burst_cnt;
        gnt       = '0;
        gnt_idx   = owner;
        keep      = (state == BURST) && bus.req[owner] && !bus.fifo_empty &&
                    (burst_cnt < BW'(MAX_BURST));
        // Leaving a burst hands priority to the requester after the owner.
        pick_ptr  = ptr;
        if (state == BURST) begin
            pick_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end

        if (keep) begin
            gnt[owner] = 1'b1;
            burst_nxt  = burst_cnt + 1'b1;
        end else begin
            ptr_nxt = pick_ptr;
            if (pick_any && !bus.fifo_empty) begin
                gnt       = pick_gnt;
                gnt_idx   = pick_idx;
                owner_nxt = pick_idx;
                burst_nxt = BW'(1);
                state_nxt = BURST;
            end else begin
                burst_nxt = '0;
                state_nxt = IDLE;
            end
        end

        // No read may be issued while reset is being applied.
        if (RST) begin
            gnt = '0;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.fifo_rd_en = |gnt;

    always_comb begin
        in_flight = |gnt;
        for (int k = 0; k < RD_LAT - 1; k++) begin
            in_flight = in_flight | pipe[k].valid;
        end
        ret_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            ret_sel[i] = pipe[RD_LAT-1].valid &&
                         (pipe[RD_LAT-1].idx == TAG_IDX_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            owner      <= '0;
            ptr        <= '0;
            burst_cnt  <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe[k] <= '0;
            end
            bus.rvalid <= '0;
            bus.rerr   <= '0;
            bus.rdata  <= '0;
            bus.busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
            pipe[0]   <= '{valid: |gnt, idx: TAG_IDX_W'(gnt_idx)};
            for (int k = 1; k < RD_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
            bus.rvalid <= bus.fifo_rd_err ? '0 : ret_sel;
            bus.rerr   <= bus.fifo_rd_err ? ret_sel : '0;
            if (pipe[RD_LAT-1].valid) begin
                bus.rdata <= bus.fifo_rd_data;
            end
            bus.busy <= in_flight || (state_nxt == BURST);
        end
    end

`ifdef FIFO_RD_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST || stats_clr) begin
            gnt_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && (gnt_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    gnt_cnt[i*16 +: 16] <= gnt_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter
//   Vector-table bench for fifo_rd_arbiter (NREQ=4, RD_LAT=2, MAX_BURST=4).
//   Inputs are applied 1 ns after each rising edge and outputs sampled 3 ns
//   later, so registered outputs show the state left by the previous edge.
module tb_fifo_rd_arbiter;
    localparam int NREQ      = 4;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fifo_rd_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

`ifdef FIFO_RD_ARB_STATS_EN
    logic               stats_clr;
    logic [NREQ*16-1:0] gnt_cnt;
`endif

    fifo_rd_arbiter #(
        .NREQ      (NREQ),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef FIFO_RD_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .gnt_cnt   (gnt_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        empty;
        logic [31:0] data;
        logic        err;
        logic [3:0]  gnt;
        logic        chk_ret;
        logic [3:0]  rvalid;
        logic [3:0]  rerr;
        logic [31:0] rdata;
        logic        chk_busy;
        logic        busy;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;
    logic [3:0] rot [22];

    function automatic void add(logic rst, logic [3:0] req, logic empty,
                                logic [31:0] data, logic err, logic [3:0] gnt,
                                logic chk_ret, logic [3:0] rv, logic [3:0] re,
                                logic [31:0] rd, logic chk_busy, logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.empty = empty; v.data = data; v.err = err;
        v.gnt = gnt; v.chk_ret = chk_ret; v.rvalid = rv; v.rerr = re;
        v.rdata = rd; v.chk_busy = chk_busy; v.busy = busy;
        vq.push_back(v);
    endfunction

    function automatic void add_g(logic [3:0] req, logic empty, logic [3:0] gnt);
        add(1'b0, req, empty, 32'h0, 1'b0, gnt, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    endfunction

    function automatic void add_rst();
        add(1'b1, 4'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        RST              = 1'b1;
        bus.req          = '0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;
        bus.fifo_rd_err  = 1'b0;
`ifdef FIFO_RD_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        rot = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2,
                4'h4, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8,
                4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2};

        // Reset values
        add_rst();
        add(0, 4'h0, 0, 32'h0, 0, 4'h0, 1, 4'h0, 4'h0, 32'h0, 1, 1'b0);

        // Full rotation with MAX_BURST=4, wrapping back to requester 0
        for (int i = 0; i < 22; i++) begin
            add(0, 4'hF, 0, 32'h11, 0, rot[i], 0, 4'h0, 4'h0, 32'h0, 1, (i != 0));
        end

        // Reset mid-burst (owner 1) with two reads in flight
        add(1, 4'h0, 0, 32'h55, 0, 4'h0, 0, 4'h0, 4'h0, 32'h0, 0, 1'b0);
        add(0, 4'hF, 0, 32'h55, 0, 4'h1, 1, 4'h0, 4'h0, 32'h0, 1, 1'b0);
        add(0, 4'h0, 0, 32'h55, 0, 4'h0, 1, 4'h0, 4'h0, 32'h0, 1, 1'b1);
        add(0, 4'h0, 0, 32'h77, 0, 4'h0, 1, 4'h0, 4'h0, 32'h0, 0, 1'b0);
        add(0, 4'h0, 0, 32'h00, 0, 4'h0, 1, 4'h1, 4'h0, 32'h77, 0, 1'b0);

        // req[0] drops mid-burst: hand-off to requester 2 with no bubble
        add_rst();
        add_g(4'h5, 0, 4'h1);
        add_g(4'h5, 0, 4'h1);
        add_g(4'h4, 0, 4'h4);
        add_g(4'h0, 0, 4'h0);

        // Empty FIFO blocks grants; release grants at pointer (3), then wrap to 0
        add_g(4'hF, 1, 4'h0);
        add_g(4'hF, 1, 4'h0);
        add_g(4'hF, 1, 4'h0);
        add_g(4'hF, 1, 4'h0);
        add_g(4'hF, 0, 4'h8);
        add_g(4'h0, 0, 4'h0);
        add_g(4'hF, 0, 4'h1);
        add_g(4'h0, 0, 4'h0);

        // Returns for reads by 2, 3, 2, then an errored read by 1
        add_rst();
        add(0, 4'h4, 0, 32'h0,      0, 4'h4, 1, 4'h0, 4'h0, 32'h0,      0, 1'b0);
        add(0, 4'h8, 0, 32'h0,      0, 4'h8, 1, 4'h0, 4'h0, 32'h0,      0, 1'b0);
        add(0, 4'h4, 0, 32'hA,      0, 4'h4, 1, 4'h0, 4'h0, 32'h0,      0, 1'b0);
        add(0, 4'h0, 0, 32'hB,      0, 4'h0, 1, 4'h4, 4'h0, 32'hA,      0, 1'b0);
        add(0, 4'h0, 0, 32'hC,      0, 4'h0, 1, 4'h8, 4'h0, 32'hB,      0, 1'b0);
        add(0, 4'h0, 0, 32'h0,      0, 4'h0, 1, 4'h4, 4'h0, 32'hC,      0, 1'b0);
        add(0, 4'h0, 0, 32'h0,      0, 4'h0, 1, 4'h0, 4'h0, 32'hC,      0, 1'b0);
        add(0, 4'h2, 0, 32'h0,      0, 4'h2, 1, 4'h0, 4'h0, 32'hC,      0, 1'b0);
        add(0, 4'h0, 0, 32'h0,      0, 4'h0, 1, 4'h0, 4'h0, 32'hC,      0, 1'b0);
        add(0, 4'h0, 0, 32'hDEAD,   1, 4'h0, 1, 4'h0, 4'h0, 32'hC,      0, 1'b0);
        add(0, 4'h0, 0, 32'h0,      0, 4'h0, 1, 4'h0, 4'h2, 32'hDEAD,   0, 1'b0);
        add(0, 4'h0, 0, 32'h0,      0, 4'h0, 1, 4'h0, 4'h0, 32'hDEAD,   0, 1'b0);

        for (int n = 0; n < vq.size(); n++) begin
            vec_t v;
            v = vq[n];
            @(posedge CLK);
            #1;
            RST              = v.rst;
            bus.req          = v.req;
            bus.fifo_empty   = v.empty;
            bus.fifo_rd_data = v.data;
            bus.fifo_rd_err  = v.err;
            #3;
            check($sformatf("gnt[%0d]", n), 32'(bus.gnt), 32'(v.gnt));
            check($sformatf("fifo_rd_en[%0d]", n), 32'(bus.fifo_rd_en), 32'(|v.gnt));
            if (v.chk_ret) begin
                check($sformatf("rvalid[%0d]", n), 32'(bus.rvalid), 32'(v.rvalid));
                check($sformatf("rerr[%0d]", n), 32'(bus.rerr), 32'(v.rerr));
                check($sformatf("rdata[%0d]", n), bus.rdata, v.rdata);
            end
            if (v.chk_busy) begin
                check($sformatf("busy[%0d]", n), 32'(bus.busy), 32'(v.busy));
            end
        end

`ifdef FIFO_RD_ARB_STATS_EN
        // One grant to requester 1 since the last reset; clear wins over a new grant.
        @(posedge CLK);
        #1;
        bus.req = 4'h0;
        #3;
        check("gnt_cnt1", 32'(gnt_cnt[31:16]), 32'd1);
        @(posedge CLK);
        #1;
        bus.req   = 4'h2;
        stats_clr = 1'b1;
        @(posedge CLK);
        #1;
        bus.req   = 4'h0;
        stats_clr = 1'b0;
        #3;
        check("gnt_cnt1_clr", 32'(gnt_cnt[31:16]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
